// File: rtl/cpu_isa_pkg.sv
// Shared definitions for the 4-bit CPU: opcode constants and the program loader state encoding.
package cpu_isa_pkg;

   localparam logic [3:0] OP_LDA  = 4'd0;
   localparam logic [3:0] OP_LDB  = 4'd1;
   localparam logic [3:0] OP_LDO  = 4'd2;
   localparam logic [3:0] OP_LDSA = 4'd3;
   localparam logic [3:0] OP_LDSB = 4'd4;
   localparam logic [3:0] OP_LSH  = 4'd5;
   localparam logic [3:0] OP_RSH  = 4'd6;
   localparam logic [3:0] OP_CLR  = 4'd7;
   localparam logic [3:0] OP_SNZA = 4'd8;
   localparam logic [3:0] OP_SNZS = 4'd9;
   localparam logic [3:0] OP_ADD  = 4'd10;
   localparam logic [3:0] OP_SUB  = 4'd11;
   localparam logic [3:0] OP_XOR  = 4'd14;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Host-side nibble stream into the program loader: load control plus valid/ready data.
interface program_loader_if;

   logic       loadStart;
   logic       loadEnd;
   logic [3:0] nibbleIn;
   logic       nibbleValid;
   logic       nibbleReady;

   modport master (
      output loadStart, loadEnd, nibbleIn, nibbleValid,
      input  nibbleReady
   );

   modport slave (
      input  loadStart, loadEnd, nibbleIn, nibbleValid,
      output nibbleReady
   );

endinterface

// File: rtl/program_loader_ram.sv
// Program store array: one synchronous write port, one asynchronous read port, no reset on contents.
module program_ram #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [3:0]            wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [3:0]            rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [3:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Writable program store: clears itself to CLR, then accepts a host nibble stream from address 0
// while holding the CPU; serves fetches combinationally in RUN.
module program_loader
   import cpu_isa_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   program_loader_if.slave       host,
   input  logic [ADDR_WIDTH-1:0] addressIn,
   output logic [3:0]            dataOut,
   output logic                  cpuHold,
   output logic                  loadDone,
   output logic [ADDR_WIDTH:0]   loadCount,
   output logic [3:0]            checksum
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   loader_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  pending_q, pending_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [3:0]            csum_q, csum_d;
   logic                  hold_q, hold_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;

   logic                  ram_we;
   logic [3:0]            ram_wdata;
   logic [3:0]            ram_rdata;
   logic                  accept;

   assign accept = ready_q && host.nibbleValid;

   // One address counter serves as clearAddr in CLEAR and writeAddr in LOAD; CLEAR wraps it back to 0.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pending_d = pending_q;
      count_d   = count_q;
      csum_d    = csum_q;
      done_d    = 1'b0;
      ram_we    = 1'b0;
      ram_wdata = OP_CLR;

      case (state_q)
         ST_CLEAR: begin
            ram_we = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == LAST_ADDR) state_d = pending_q ? ST_LOAD : ST_RUN;
         end
         ST_RUN: begin
            if (host.loadStart) begin
               state_d   = ST_CLEAR;
               pending_d = 1'b1;
               count_d   = '0;
               csum_d    = '0;
               addr_d    = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               ram_we    = 1'b1;
               ram_wdata = host.nibbleIn;
               addr_d    = addr_q + 1'b1;
               count_d   = count_q + 1'b1;
               csum_d    = csum_q ^ host.nibbleIn;
            end
            if (host.loadEnd || (accept && addr_q == LAST_ADDR)) begin
               state_d   = ST_RUN;
               pending_d = 1'b0;
               addr_d    = '0;
               done_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            addr_d  = '0;
         end
      endcase

      hold_d  = (state_d != ST_RUN);
      ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         addr_q    <= '0;
         pending_q <= 1'b0;
         count_q   <= '0;
         csum_q    <= '0;
         hold_q    <= 1'b1;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         csum_q    <= csum_d;
         hold_q    <= hold_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   program_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (addr_q),
      .wdata (ram_wdata),
      .raddr (addressIn),
      .rdata (ram_rdata)
   );

   assign dataOut          = (state_q == ST_RUN) ? ram_rdata : OP_CLR;
   assign cpuHold          = hold_q;
   assign loadDone         = done_q;
   assign loadCount        = count_q;
   assign checksum         = csum_q;
   assign host.nibbleReady = ready_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at ADDR_WIDTH=4: clear, partial/full/gapped/back-to-back loads, mid-load reset.
module tb_program_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] addressIn;
   logic [3:0]    dataOut;
   logic          cpuHold;
   logic          loadDone;
   logic [AW:0]   loadCount;
   logic [3:0]    checksum;

   program_loader_if hif ();

   program_loader #(
      .ADDR_WIDTH (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .host      (hif.slave),
      .addressIn (addressIn),
      .dataOut   (dataOut),
      .cpuHold   (cpuHold),
      .loadDone  (loadDone),
      .loadCount (loadCount),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;

   logic [3:0] vec [DEPTH];
   logic [3:0] image [DEPTH];

   always @(negedge clk) if (loadDone === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns number of edges until cpuHold falls, bounded.
   task automatic count_hold(output int n);
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (cpuHold === 1'b0) break;
      end
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         addressIn = a[AW-1:0];
         #1;
         chk($sformatf("%s_rd%0d", tag, a), {28'd0, dataOut}, {28'd0, image[a]});
      end
   endtask

   task automatic start_load(input string tag);
      int n;
      hif.loadStart = 1'b1;
      tick();
      hif.loadStart = 1'b0;
      chk({tag, "_hold_clear"}, {31'd0, cpuHold}, 32'd1);
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (hif.nibbleReady === 1'b1) break;
      end
      chk({tag, "_clear_cycles"}, n, 32'd16);
   endtask

   // Streams n nibbles of vec; gaps inserts idle cycles with a junk nibble on the bus.
   task automatic stream(input int n, input bit use_end, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && (i % 3 == 1)) begin
            hif.nibbleIn    = 4'hF;
            hif.nibbleValid = 1'b0;
            tick();
            if (i == 4) begin
               tick();
            end
         end
         hif.nibbleIn    = vec[i];
         hif.nibbleValid = 1'b1;
         hif.loadEnd     = use_end && (i == n - 1);
         tick();
         hif.nibbleValid = 1'b0;
         hif.loadEnd     = 1'b0;
         hif.nibbleIn    = 4'h0;
      end
   endtask

   task automatic finish_load(input string tag, input int n);
      logic [3:0] x;
      int d0;
      x = 4'h0;
      for (int a = 0; a < DEPTH; a++) begin
         image[a] = (a < n) ? vec[a] : 4'h7;
         if (a < n) x = x ^ vec[a];
      end
      d0 = done_cnt;
      chk({tag, "_done"},  {31'd0, loadDone}, 32'd1);
      chk({tag, "_hold"},  {31'd0, cpuHold},  32'd0);
      chk({tag, "_ready"}, {31'd0, hif.nibbleReady}, 32'd0);
      chk({tag, "_count"}, {27'd0, loadCount}, n);
      chk({tag, "_csum"},  {28'd0, checksum},  {28'd0, x});
      tick();
      chk({tag, "_done_low"}, {31'd0, loadDone}, 32'd0);
      chk({tag, "_one_pulse"}, done_cnt - d0, 32'd1);
      read_all(tag);
   endtask

   initial begin
      int n;
      rst_n           = 1'b1;
      addressIn       = '0;
      hif.loadStart   = 1'b0;
      hif.loadEnd     = 1'b0;
      hif.nibbleIn    = 4'h0;
      hif.nibbleValid = 1'b0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_hold",  {31'd0, cpuHold},  32'd1);
      chk("rst_ready", {31'd0, hif.nibbleReady}, 32'd0);
      chk("rst_done",  {31'd0, loadDone}, 32'd0);
      chk("rst_count", {27'd0, loadCount}, 32'd0);
      chk("rst_csum",  {28'd0, checksum},  32'd0);
      chk("rst_data",  {28'd0, dataOut},   32'd7);
      rst_n = 1'b1;

      count_hold(n);
      chk("init_clear_cycles", n, 32'd16);
      chk("init_count", {27'd0, loadCount}, 32'd0);
      chk("init_no_done", done_cnt, 32'd0);
      for (int a = 0; a < DEPTH; a++) image[a] = 4'h7;
      read_all("init");

      // Basic load with loadEnd on the last nibble.
      vec[0] = 4'd0; vec[1] = 4'd1; vec[2] = 4'd10; vec[3] = 4'd2;
      start_load("ld4");
      chk("ld4_hold_load", {31'd0, cpuHold}, 32'd1);
      chk("ld4_data_held", {28'd0, dataOut}, 32'd7);
      stream(4, 1'b1, 1'b0);
      chk("ld4_csum_const", {28'd0, checksum}, 32'h9);
      finish_load("ld4", 4);

      // Full load, auto-exit after the 16th accept.
      for (int i = 0; i < DEPTH; i++) vec[i] = 4'(15 - i) ^ 4'(i << 1);
      start_load("full");
      stream(16, 1'b0, 1'b0);
      chk("full_count16", {27'd0, loadCount}, 32'd16);
      finish_load("full", 16);

      // Gapped valid with junk on the bus while invalid.
      vec[0] = 4'd3; vec[1] = 4'd12; vec[2] = 4'd5; vec[3] = 4'd9;
      vec[4] = 4'd14; vec[5] = 4'd1; vec[6] = 4'd8;
      start_load("gap");
      stream(7, 1'b1, 1'b1);
      finish_load("gap", 7);

      // Back-to-back: 10 nibbles then 3 nibbles.
      for (int i = 0; i < 10; i++) vec[i] = 4'(i + 3);
      start_load("b2b10");
      stream(10, 1'b1, 1'b0);
      finish_load("b2b10", 10);
      vec[0] = 4'd11; vec[1] = 4'd0; vec[2] = 4'd6;
      start_load("b2b3");
      stream(3, 1'b1, 1'b0);
      finish_load("b2b3", 3);

      // Empty load.
      start_load("empty");
      hif.loadEnd = 1'b1;
      tick();
      hif.loadEnd = 1'b0;
      finish_load("empty", 0);

      // Reset mid-load after 5 nibbles.
      for (int i = 0; i < 5; i++) vec[i] = 4'(i + 1);
      start_load("rst");
      stream(5, 1'b0, 1'b0);
      chk("rst_mid_count", {27'd0, loadCount}, 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_hold",  {31'd0, cpuHold},  32'd1);
      chk("arst_ready", {31'd0, hif.nibbleReady}, 32'd0);
      chk("arst_count", {27'd0, loadCount}, 32'd0);
      chk("arst_csum",  {28'd0, checksum},  32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      hif.loadStart = 1'b1;
      tick();
      hif.loadStart = 1'b0;
      count_hold(n);
      chk("arst_clear_cycles", n + 2, 32'd16);
      for (int k = 0; k < 3; k++) tick();
      chk("arst_ign_hold",  {31'd0, cpuHold}, 32'd0);
      chk("arst_ign_ready", {31'd0, hif.nibbleReady}, 32'd0);
      for (int a = 0; a < DEPTH; a++) image[a] = 4'h7;
      read_all("arst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
